x_settle_checker: RTL and testbench

- Consumer-side partner of the X-propagation test netlists: observes dual-rail three-valued outputs of a DUT and decides when they resolve from X to known values.
- Once all cared bits are known, compares them against expected values and reports pass, fail or timeout through a valid/ready result port.
- Sits in the simulator self-check harness between the netlist under test and the result log.
- Keeps a saturating failure counter.

---
 rtl/x_check_pkg.sv | 34 +++
 rtl/x_settle_checker_ternary_cmp.sv | 22 ++
 rtl/x_settle_checker.sv | 136 +++++++++++++
 tb/tb_x_settle_checker.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/x_check_pkg.sv
// Shared types for the X-settle result checker.
// Holds state encoding, result bundle and width helpers.
package x_check_pkg;

    localparam int W_DEF       = 4;
    localparam int TIMEOUT_DEF = 8;
    localparam int FW_DEF      = 16;

    // Bits needed to hold values 0..v-1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    localparam int CW_DEF = clog2(TIMEOUT_DEF + 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        REPORT
    } state_e;

    typedef struct packed {
        logic              pass;
        logic              timeout;
        logic [W_DEF-1:0]  mismatch;
        logic [CW_DEF-1:0] settle;
    } result_t;

endpackage

// File: rtl/x_settle_checker_ternary_cmp.sv
// Dual-rail ternary compare of observed bits against expected.
// Flags any cared bit still X and the cared known bits that differ.
module ternary_cmp
    import x_check_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [W-1:0] obs_val,
    input  logic [W-1:0] obs_known,
    input  logic [W-1:0] exp_val,
    input  logic [W-1:0] exp_care,
    output logic         unres_any,
    output logic [W-1:0] diff
);

    // Unresolved cared bits and known cared bits that disagree.
    always_comb begin
        unres_any = |(exp_care & ~obs_known);
        diff      = exp_care & obs_known & (obs_val ^ exp_val);
    end

endmodule

// File: rtl/x_settle_checker.sv
// Waits for cared dual-rail outputs to leave X, then grades them.
// Reports pass/fail/timeout over valid/ready and counts failures.
module x_settle_checker
    import x_check_pkg::*;
#(
    parameter int W       = W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CW      = clog2(TIMEOUT + 1),
    parameter int FW      = FW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [W-1:0]  obs_val,
    input  logic [W-1:0]  obs_known,
    input  logic [W-1:0]  exp_val,
    input  logic [W-1:0]  exp_care,
    output logic          busy,
    output logic          res_valid,
    input  logic          res_ready,
    output logic          res_pass,
    output logic          res_timeout,
    output logic [W-1:0]  res_mismatch,
    output logic [CW-1:0] res_settle,
    output logic [FW-1:0] fail_count
);

    typedef struct packed {
        logic          pass;
        logic          timeout;
        logic [W-1:0]  mismatch;
        logic [CW-1:0] settle;
    } res_t;

    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  exp_q, exp_d;
    logic [W-1:0]  care_q, care_d;
    res_t          res_q, res_d;
    logic [FW-1:0] fail_q, fail_d;

    logic          unres_any;
    logic [W-1:0]  diff;

    ternary_cmp #(
        .W(W)
    ) u_cmp (
        .obs_val   (obs_val),
        .obs_known (obs_known),
        .exp_val   (exp_q),
        .exp_care  (care_q),
        .unres_any (unres_any),
        .diff      (diff)
    );

    // Next-state, latch of expectations, result capture and fail counting.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        care_d  = care_q;
        res_d   = res_q;
        fail_d  = fail_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    exp_d   = exp_val;
                    care_d  = exp_care;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (!unres_any) begin
                    res_d.pass     = (diff == '0);
                    res_d.timeout  = 1'b0;
                    res_d.mismatch = diff;
                    res_d.settle   = cnt_q;
                    state_d        = REPORT;
                end else if (cnt_q == CNT_LAST) begin
                    res_d.pass     = 1'b0;
                    res_d.timeout  = 1'b1;
                    res_d.mismatch = diff;
                    res_d.settle   = cnt_q;
                    state_d        = REPORT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            REPORT: begin
                if (res_ready) begin
                    state_d = IDLE;
                    if (!res_q.pass && (fail_q != '1)) begin
                        fail_d = fail_q + FW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            exp_q   <= '0;
            care_q  <= '0;
            res_q   <= '0;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            care_q  <= care_d;
            res_q   <= res_d;
            fail_q  <= fail_d;
        end
    end

    // Output decode straight from registered state.
    always_comb begin
        busy         = (state_q != IDLE);
        res_valid    = (state_q == REPORT);
        res_pass     = res_q.pass;
        res_timeout  = res_q.timeout;
        res_mismatch = res_q.mismatch;
        res_settle   = res_q.settle;
        fail_count   = fail_q;
    end

endmodule

// File: tb/tb_x_settle_checker.sv
// Directed and randomized bench for x_settle_checker.
// Expected results come from a per-transaction settle model.
module tb_x_settle_checker;

    localparam int W  = 4;
    localparam int TO = 8;
    localparam int CW = 4;
    localparam int FW = 3;
    localparam int FMAX = (1 << FW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  obs_val;
    logic [W-1:0]  obs_known;
    logic [W-1:0]  exp_val;
    logic [W-1:0]  exp_care;
    logic          busy;
    logic          res_valid;
    logic          res_ready;
    logic          res_pass;
    logic          res_timeout;
    logic [W-1:0]  res_mismatch;
    logic [CW-1:0] res_settle;
    logic [FW-1:0] fail_count;

    always #5 clk = ~clk;

    x_settle_checker #(
        .W(W),
        .TIMEOUT(TO),
        .CW(CW),
        .FW(FW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .obs_val      (obs_val),
        .obs_known    (obs_known),
        .exp_val      (exp_val),
        .exp_care     (exp_care),
        .busy         (busy),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_pass     (res_pass),
        .res_timeout  (res_timeout),
        .res_mismatch (res_mismatch),
        .res_settle   (res_settle),
        .fail_count   (fail_count)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int fc_m  = 0;

    logic [W-1:0] kn_a [TO];
    logic [W-1:0] vl_a [TO];

    logic         m_pass;
    logic         m_to;
    logic [W-1:0] m_mis;
    int           m_k;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // First SETTLE cycle where every cared bit is known, else timeout.
    task automatic model(input logic [W-1:0] e, input logic [W-1:0] c);
        m_k  = TO - 1;
        m_to = 1'b1;
        for (int i = 0; i < TO; i++) begin
            if (m_to && ((c & ~kn_a[i]) == '0)) begin
                m_k  = i;
                m_to = 1'b0;
            end
        end
        m_mis  = c & kn_a[m_k] & (vl_a[m_k] ^ e);
        m_pass = !m_to && (m_mis == '0);
    endtask

    task automatic fill(input logic [W-1:0] kb, input int sw,
                        input logic [W-1:0] ka, input logic [W-1:0] v);
        for (int i = 0; i < TO; i++) begin
            if (i < sw) begin
                kn_a[i] = kb;
                vl_a[i] = W'($urandom);
            end else begin
                kn_a[i] = ka;
                vl_a[i] = v;
            end
        end
    endtask

    task automatic check_res(input string tag);
        chk({tag, "_valid"}, 32'(res_valid), 32'(1));
        chk({tag, "_busy"}, 32'(busy), 32'(1));
        chk({tag, "_pass"}, 32'(res_pass), 32'(m_pass));
        chk({tag, "_timeout"}, 32'(res_timeout), 32'(m_to));
        chk({tag, "_mismatch"}, 32'(res_mismatch), 32'(m_mis));
        chk({tag, "_settle"}, 32'(res_settle), 32'(m_k));
    endtask

    task automatic run_txn(input logic [W-1:0] e, input logic [W-1:0] c,
                           input int hold, input bit s_hs);
        model(e, c);
        start    = 1'b1;
        exp_val  = e;
        exp_care = c;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i <= m_k; i++) begin
            obs_known = kn_a[i];
            obs_val   = vl_a[i];
            exp_val   = W'($urandom);
            exp_care  = W'($urandom);
            start     = 1'($urandom_range(0, 1));
            chk("settle_busy", 32'(busy), 32'(1));
            chk("settle_valid", 32'(res_valid), 32'(0));
            @(negedge clk);
        end
        obs_known = W'($urandom);
        obs_val   = W'($urandom);
        start     = 1'b0;
        for (int h = 0; h <= hold; h++) begin
            check_res("report");
            if (h < hold) begin
                res_ready = 1'b0;
                start     = 1'($urandom_range(0, 1));
            end else begin
                res_ready = 1'b1;
                start     = s_hs;
            end
            @(negedge clk);
        end
        if (!m_pass && fc_m != FMAX) fc_m++;
        res_ready = 1'b0;
        start     = 1'b0;
        chk("hs_valid", 32'(res_valid), 32'(0));
        chk("hs_busy", 32'(busy), 32'(0));
        chk("fail_count", 32'(fail_count), 32'(fc_m));
        @(negedge clk);
        chk("no_restart", 32'(busy), 32'(0));
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        res_ready = 1'b0;
        obs_val   = '0;
        obs_known = '0;
        exp_val   = '0;
        exp_care  = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_valid", 32'(res_valid), 32'(0));
        chk("rst_pass", 32'(res_pass), 32'(0));
        chk("rst_timeout", 32'(res_timeout), 32'(0));
        chk("rst_mismatch", 32'(res_mismatch), 32'(0));
        chk("rst_settle", 32'(res_settle), 32'(0));
        chk("rst_fail", 32'(fail_count), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);

        fill(4'hF, 0, 4'hF, 4'h5);
        run_txn(4'h5, 4'hF, 0, 1'b0);
        fill(4'h0, 3, 4'hF, 4'h5);
        run_txn(4'h5, 4'hF, 1, 1'b0);
        fill(4'hF, 0, 4'hF, 4'h7);
        run_txn(4'h5, 4'hF, 0, 1'b0);
        fill(4'hE, TO, 4'hE, 4'h0);
        run_txn(4'h5, 4'h1, 2, 1'b1);
        fill(4'hF, 0, 4'hF, 4'h5);
        run_txn(4'h5, 4'hF, 5, 1'b1);
        fill(4'h0, TO, 4'h0, 4'h0);
        run_txn(4'hA, 4'h0, 0, 1'b0);

        start     = 1'b1;
        exp_val   = 4'h5;
        exp_care  = 4'hF;
        obs_known = 4'h0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        fc_m  = 0;
        chk("mid_rst_busy", 32'(busy), 32'(0));
        chk("mid_rst_valid", 32'(res_valid), 32'(0));
        chk("mid_rst_fail", 32'(fail_count), 32'(0));
        chk("mid_rst_pass", 32'(res_pass), 32'(0));
        fill(4'hF, 0, 4'hF, 4'h5);
        run_txn(4'h5, 4'hF, 0, 1'b0);

        for (int t = 0; t < 60; t++) begin
            logic [W-1:0] e;
            logic [W-1:0] c;
            bit           stuck;
            e     = W'($urandom);
            c     = W'($urandom);
            stuck = ($urandom_range(0, 4) == 0);
            for (int i = 0; i < TO; i++) begin
                kn_a[i] = stuck ? ~c : W'($urandom);
                vl_a[i] = W'($urandom);
            end
            run_txn(e, c, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
